// File: rtl/product_bcd_converter_pkg.sv
// Shared constants and types for the signed-product to sign-magnitude BCD converter.
package product_bcd_converter_pkg;

  localparam int unsigned DW   = 16;
  localparam int unsigned NDIG = 10;

  typedef enum logic [1:0] {
    IDLE,
    ABS,
    SHIFT,
    DONE
  } bcd_state_e;

  // Counter must hold the value 2*dw.
  function automatic int unsigned cnt_width(input int unsigned dw);
    return $clog2(2 * dw + 1);
  endfunction

  localparam int unsigned CNTW = cnt_width(DW);

endpackage

// File: rtl/product_bcd_converter_if.sv
// Multiplier-to-converter link: product handoff plus the converted result and status.
interface product_bcd_converter_if #(
  parameter int unsigned DW   = product_bcd_converter_pkg::DW,
  parameter int unsigned NDIG = product_bcd_converter_pkg::NDIG
);
  logic                  ready;
  logic [2*DW-1:0]       product;
  logic [4*NDIG-1:0]     bcd;
  logic                  sign;
  logic                  valid;
  logic                  done;
  logic                  busy;
  logic                  overrun;

  modport master (
    output ready, product,
    input  bcd, sign, valid, done, busy, overrun
  );

  modport slave (
    input  ready, product,
    output bcd, sign, valid, done, busy, overrun
  );
endinterface

// File: rtl/product_bcd_converter_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more before the shift.
module bcd_digit_adj (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

// File: rtl/product_bcd_converter.sv
// Captures a signed product on each ready rise and converts it to sign-magnitude BCD,
// one bit per cycle, holding the last result for downstream readout.
module product_bcd_converter #(
  parameter int unsigned DW   = product_bcd_converter_pkg::DW,
  parameter int unsigned NDIG = product_bcd_converter_pkg::NDIG
) (
  input  logic                    clk,
  input  logic                    rst,
  product_bcd_converter_if.slave  bus
);
  import product_bcd_converter_pkg::*;

  localparam int unsigned PW = 2 * DW;
  localparam int unsigned BW = 4 * NDIG;
  localparam int unsigned CW = cnt_width(DW);

  bcd_state_e        state;
  logic              ready_q;
  logic [PW-1:0]     hold;
  logic [PW-1:0]     mag;
  logic              sign_w;
  logic [BW-1:0]     work;
  logic [BW-1:0]     adj;
  logic [CW-1:0]     cnt;
  logic [BW-1:0]     bcd_r;
  logic              sign_r;
  logic              valid_r;
  logic              done_r;
  logic              busy_r;
  logic              overrun_r;
  logic              rise;

  assign rise = bus.ready & ~ready_q;

  for (genvar g = 0; g < NDIG; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d (work[4*g +: 4]),
      .q (adj[4*g +: 4])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ready_q   <= 1'b0;
      hold      <= '0;
      mag       <= '0;
      sign_w    <= 1'b0;
      work      <= '0;
      cnt       <= '0;
      bcd_r     <= '0;
      sign_r    <= 1'b0;
      valid_r   <= 1'b0;
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      ready_q <= bus.ready;
      done_r  <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            hold   <= bus.product;
            busy_r <= 1'b1;
            state  <= ABS;
          end
        end
        ABS: begin
          // Two's-complement negate in PW bits maps the most negative value onto itself,
          // which read as unsigned is exactly its magnitude.
          sign_w <= hold[PW-1];
          mag    <= hold[PW-1] ? -hold : hold;
          work   <= '0;
          cnt    <= '0;
          state  <= SHIFT;
          if (rise) overrun_r <= 1'b1;
        end
        SHIFT: begin
          {work, mag} <= {adj, mag} << 1;
          cnt         <= cnt + CW'(1);
          if (cnt == CW'(PW - 1)) state <= DONE;
          if (rise) overrun_r <= 1'b1;
        end
        DONE: begin
          bcd_r   <= work;
          sign_r  <= sign_w;
          done_r  <= 1'b1;
          valid_r <= 1'b1;
          // A rise landing here starts the next conversion back-to-back.
          if (rise) begin
            hold  <= bus.product;
            state <= ABS;
          end else begin
            busy_r <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          busy_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.bcd     = bcd_r;
  assign bus.sign    = sign_r;
  assign bus.valid   = valid_r;
  assign bus.done    = done_r;
  assign bus.busy    = busy_r;
  assign bus.overrun = overrun_r;

endmodule

// File: tb/tb_product_bcd_converter.sv
// Directed and random checks of product_bcd_converter against an arithmetic BCD model.
module tb_product_bcd_converter;
  localparam int unsigned DW   = 16;
  localparam int unsigned NDIG = 10;
  localparam int          LAT  = 2 * DW + 3;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  product_bcd_converter_if #(.DW(DW), .NDIG(NDIG)) bus ();

  product_bcd_converter #(.DW(DW), .NDIG(NDIG)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Magnitude digits by repeated division; sign from the two's-complement value.
  function automatic logic [4*NDIG-1:0] ref_bcd(input logic [2*DW-1:0] p);
    longint m;
    logic [4*NDIG-1:0] r;
    m = longint'($signed(p));
    if (m < 0) m = -m;
    r = '0;
    for (int i = 0; i < NDIG; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic logic ref_sign(input logic [2*DW-1:0] p);
    return $signed(p) < 0;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_bcd"},     64'(bus.bcd),     64'd0);
    check({tag, "_sign"},    64'(bus.sign),    64'd0);
    check({tag, "_valid"},   64'(bus.valid),   64'd0);
    check({tag, "_done"},    64'(bus.done),    64'd0);
    check({tag, "_busy"},    64'(bus.busy),    64'd0);
    check({tag, "_overrun"}, 64'(bus.overrun), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One-cycle ready pulse, then count negedges until done (lat = -1 on timeout).
  task automatic run_pulse(input logic [2*DW-1:0] p, output int lat);
    bus.product = p;
    bus.ready   = 1'b1;
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (k == 1) bus.ready = 1'b0;
      if (bus.done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic convert_check(input logic [2*DW-1:0] p);
    int lat;
    run_pulse(p, lat);
    check($sformatf("lat_%0h", p),   64'(lat),       64'(LAT));
    check($sformatf("bcd_%0h", p),   64'(bus.bcd),   64'(ref_bcd(p)));
    check($sformatf("sign_%0h", p),  64'(bus.sign),  64'(ref_sign(p)));
    check($sformatf("valid_%0h", p), 64'(bus.valid), 64'd1);
    check($sformatf("busy_%0h", p),  64'(bus.busy),  64'd0);
    @(negedge clk);
    check($sformatf("done_pulse_%0h", p), 64'(bus.done), 64'd0);
  endtask

  initial begin
    logic [2*DW-1:0] vals [$];
    int dones;
    int lat;
    int lat2;

    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    bus.ready    = 1'b0;
    bus.product  = '0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    vals = '{32'h0000_0000, 32'd123456789, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    for (int i = 0; i < 6; i++) vals.push_back(32'($urandom));
    foreach (vals[i]) convert_check(vals[i]);

    // Level-held ready produces exactly one conversion.
    do_reset();
    bus.product = 32'd7;
    bus.ready   = 1'b1;
    dones = 0;
    lat   = -1;
    for (int k = 1; k <= 90; k++) begin
      @(negedge clk);
      if (k == 50) bus.ready = 1'b0;
      if (bus.done) begin
        dones++;
        if (lat < 0) lat = k;
      end
    end
    check("level_dones",   64'(dones),       64'd1);
    check("level_lat",     64'(lat),         64'(LAT));
    check("level_bcd",     64'(bus.bcd),     64'd7);
    check("level_overrun", 64'(bus.overrun), 64'd0);

    // Rise in the middle of SHIFT is dropped and flagged.
    do_reset();
    bus.product = 32'd7;
    bus.ready   = 1'b1;
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (k == 1) bus.ready = 1'b0;
      if (k == 12) begin
        bus.product = 32'd99;
        bus.ready   = 1'b1;
      end
      if (k == 13) bus.ready = 1'b0;
      if (bus.done) begin
        lat = k;
        break;
      end
    end
    check("ovr_lat",     64'(lat),         64'(LAT));
    check("ovr_bcd",     64'(bus.bcd),     64'd7);
    check("ovr_overrun", 64'(bus.overrun), 64'd1);
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("ovr_no_second", 64'(dones), 64'd0);

    // Rise coincident with DONE is accepted back-to-back.
    do_reset();
    bus.product = 32'd7;
    bus.ready   = 1'b1;
    lat  = -1;
    lat2 = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (k == 1) bus.ready = 1'b0;
      if (k == 34) begin
        bus.product = -32'sd42;
        bus.ready   = 1'b1;
      end
      if (k == 35) bus.ready = 1'b0;
      if (bus.done) begin
        if (lat < 0) begin
          lat = k;
          check("b2b_first_bcd",  64'(bus.bcd),  64'd7);
          check("b2b_first_busy", 64'(bus.busy), 64'd1);
        end else begin
          lat2 = k;
          break;
        end
      end
    end
    check("b2b_lat1",    64'(lat),         64'(LAT));
    check("b2b_lat2",    64'(lat2),        64'(LAT + 2 * DW + 2));
    check("b2b_bcd",     64'(bus.bcd),     64'(ref_bcd(-32'sd42)));
    check("b2b_sign",    64'(bus.sign),    64'd1);
    check("b2b_overrun", 64'(bus.overrun), 64'd0);

    // Reset partway through shifting discards the conversion.
    bus.product = -32'sd5;
    bus.ready   = 1'b1;
    dones = 0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (k == 1) bus.ready = 1'b0;
      if (k == 22) rst = 1'b1;
      if (k == 23) begin
        check_idle_outputs("midrst");
        rst = 1'b0;
      end
      if (bus.done) dones++;
    end
    check("midrst_no_done", 64'(dones), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
